display_counter: RTL and testbench

DISPLAY_COUNTER -- requirements
Module: display_counter

---
 rtl/display_counter.sv | 148 ++++++++++++++
 tb/tb_display_counter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_counter.sv
// ============================================================================
// Module      : display_counter
// Description : Debounced run/stop up/down counter with prescaler, load,
//               clear and wrap/tick pulses. Define DISPLAY_COUNTER_SATURATE_EN
//               to make the count saturate instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_counter #(
  parameter int WIDTH    = 48,
  parameter int PRESCALE = 1,
  parameter int DEBOUNCE = 16
) (
  input  logic             clk_video,
  input  logic             reset_n,
  input  logic             key_run_n,
  input  logic             key_clr_n,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             tick,
  output logic             wrap
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = $clog2(DEBOUNCE);

  // Key conditioning: bit 0 = run key, bit 1 = clear key.
  logic [1:0] keys_n;
  logic [1:0] press;

  assign keys_n = {key_clr_n, key_run_n};

  for (genvar gi = 0; gi < 2; gi++) begin : g_key
    logic          s1_q;
    logic          s2_q;
    logic          db_q;
    logic          press_q;
    logic [DW-1:0] cnt_q;

    // The counter measures how long the synchronised level has disagreed
    // with the debounced level; acceptance happens on the DEBOUNCE-th cycle.
    always_ff @(posedge clk_video) begin
      if (!reset_n) begin
        s1_q    <= 1'b1;
        s2_q    <= 1'b1;
        db_q    <= 1'b1;
        press_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        s1_q    <= keys_n[gi];
        s2_q    <= s1_q;
        press_q <= 1'b0;
        if (s2_q == db_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DW'(DEBOUNCE - 1)) begin
          db_q    <= s2_q;
          cnt_q   <= '0;
          press_q <= ~s2_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign press[gi] = press_q;
  end

  typedef enum logic [0:0] {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  state_t           state_q;
  logic             running_q;
  logic [PW-1:0]    presc_q;
  logic [PW-1:0]    presc_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tick_q;
  logic             tick_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             step;
  logic             at_limit;
  logic [WIDTH-1:0] stepped;

  assign step     = (state_q == RUNNING) && (presc_q == PW'(PRESCALE - 1));
  assign at_limit = dir ? (count_q == '0) : (count_q == '1);
  assign stepped  = dir ? (count_q - 1'b1) : (count_q + 1'b1);

  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    tick_d  = step;
    wrap_d  = 1'b0;
    if (state_q == RUNNING) begin
      presc_d = step ? '0 : presc_q + 1'b1;
    end
    // Clear beats load beats step; tick still reports a step that was overridden.
    if (press[1]) begin
      count_d = '0;
      presc_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (step) begin
`ifdef DISPLAY_COUNTER_SATURATE_EN
      if (!at_limit) begin
        count_d = stepped;
      end
`else
      count_d = stepped;
      wrap_d  = at_limit;
`endif
    end
  end

  always_ff @(posedge clk_video) begin
    if (!reset_n) begin
      state_q   <= STOPPED;
      running_q <= 1'b0;
      presc_q   <= '0;
      count_q   <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      if (press[0]) begin
        state_q   <= (state_q == RUNNING) ? STOPPED : RUNNING;
        running_q <= (state_q == STOPPED);
      end
      presc_q <= presc_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_display_counter.sv
// ============================================================================
// Module      : tb_display_counter
// Description : Directed self-checking bench for display_counter
//               (WIDTH=8, PRESCALE=3, DEBOUNCE=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_counter;

`ifdef DISPLAY_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk_video = 1'b0;
  logic       reset_n;
  logic       key_run_n;
  logic       key_clr_n;
  logic       dir;
  logic       load;
  logic [7:0] load_value;
  logic [7:0] count;
  logic       running;
  logic       tick;
  logic       wrap;

  int checks = 0;
  int errors = 0;
  int rise;
  int n;

  display_counter #(
    .WIDTH   (8),
    .PRESCALE(3),
    .DEBOUNCE(4)
  ) dut (
    .clk_video (clk_video),
    .reset_n   (reset_n),
    .key_run_n (key_run_n),
    .key_clr_n (key_clr_n),
    .dir       (dir),
    .load      (load),
    .load_value(load_value),
    .count     (count),
    .running   (running),
    .tick      (tick),
    .wrap      (wrap)
  );

  always #5 clk_video = ~clk_video;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for the next tick pulse; a timeout counts as a failure.
  task automatic wait_tick(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk_video);
      k++;
    end while (!tick && k < 20);
    check(tag, 32'(tick), 32'd1);
  endtask

  // Hold a key low long enough to be accepted, then release and let it settle.
  task automatic press_key(input bit clr);
    if (clr) key_clr_n = 1'b0; else key_run_n = 1'b0;
    repeat (8) @(negedge clk_video);
    key_clr_n = 1'b1;
    key_run_n = 1'b1;
    repeat (8) @(negedge clk_video);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    key_run_n  = 1'b1;
    key_clr_n  = 1'b1;
    dir        = 1'b0;
    load       = 1'b0;
    load_value = 8'h00;

    // Reset state
    repeat (2) @(negedge clk_video);
    check("rst_count", 32'(count), 32'h00);
    check("rst_running", 32'(running), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    reset_n = 1'b1;

    // A 3-cycle glitch is shorter than the debounce window
    key_run_n = 1'b0;
    repeat (3) @(negedge clk_video);
    key_run_n = 1'b1;
    repeat (12) @(negedge clk_video);
    check("glitch_running", 32'(running), 32'd0);
    check("glitch_count", 32'(count), 32'h00);

    // Load while stopped, then hold
    load_value = 8'h12;
    load       = 1'b1;
    @(negedge clk_video);
    load = 1'b0;
    check("load_stopped", 32'(count), 32'h12);
    repeat (5) @(negedge clk_video);
    check("hold_stopped", 32'(count), 32'h12);
    check("hold_tick", 32'(tick), 32'd0);

    // Clear while stopped
    press_key(1'b1);
    check("clr_stopped_count", 32'(count), 32'h00);
    check("clr_stopped_running", 32'(running), 32'd0);

    // Run press: latency and count after 30 cycles
    key_run_n = 1'b0;
    rise      = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_video);
      if (rise == 0 && running) rise = k;
    end
    key_run_n = 1'b1;
    check("run_latency_6_to_8", 32'(rise >= 6 && rise <= 8), 32'd1);
    repeat (((rise > 0) ? rise : 7) + 20) @(negedge clk_video);
    check("run_count_30", 32'(count), 32'h0A);

    // Tick period
    wait_tick("tick_first");
    n = 0;
    do begin
      @(negedge clk_video);
      n++;
    end while (!tick && n < 10);
    check("tick_period", 32'(n), 32'd3);

    // Up wrap from 0xFE (load right after a tick so no step collides)
    load_value = 8'hFE;
    load       = 1'b1;
    @(negedge clk_video);
    load = 1'b0;
    check("load_fe", 32'(count), 32'hFE);
    wait_tick("up_tick1");
    check("up_count1", 32'(count), 32'hFF);
    check("up_wrap1", 32'(wrap), 32'd0);
    wait_tick("up_tick2");
    check("up_count2", 32'(count), SAT ? 32'hFF : 32'h00);
    check("up_wrap2", 32'(wrap), SAT ? 32'd0 : 32'd1);
    @(negedge clk_video);
    check("up_wrap_pulse_end", 32'(wrap), 32'd0);

    // Down wrap from 0x00
    wait_tick("down_sync");
    load_value = 8'h00;
    load       = 1'b1;
    dir        = 1'b1;
    @(negedge clk_video);
    load = 1'b0;
    check("load_00", 32'(count), 32'h00);
    wait_tick("down_tick1");
    check("down_count1", 32'(count), SAT ? 32'h00 : 32'hFF);
    check("down_wrap1", 32'(wrap), SAT ? 32'd0 : 32'd1);
    @(negedge clk_video);
    check("down_wrap_pulse_end", 32'(wrap), 32'd0);
    dir = 1'b0;

    // Clear press coincident with load 0x55 while running
    key_clr_n = 1'b0;
    repeat (6) @(negedge clk_video);
    load_value = 8'h55;
    load       = 1'b1;
    @(negedge clk_video);
    load = 1'b0;
    check("clr_over_load", 32'(count), 32'h00);
    check("clr_keeps_running", 32'(running), 32'd1);
    repeat (2) @(negedge clk_video);
    check("presc_cleared_hold", 32'(count), 32'h00);
    @(negedge clk_video);
    check("presc_cleared_step", 32'(count), 32'h01);
    check("presc_cleared_tick", 32'(tick), 32'd1);
    key_clr_n = 1'b1;
    repeat (8) @(negedge clk_video);

    // Stop press, then the count holds
    press_key(1'b0);
    check("stop_running", 32'(running), 32'd0);
    load_value = 8'h3C;
    load       = 1'b1;
    @(negedge clk_video);
    load = 1'b0;
    repeat (6) @(negedge clk_video);
    check("stop_hold", 32'(count), 32'h3C);

    // Restart, then reset mid-run
    press_key(1'b0);
    check("restart_running", 32'(running), 32'd1);
    @(negedge clk_video);
    reset_n = 1'b0;
    @(negedge clk_video);
    check("midrun_rst_count", 32'(count), 32'h00);
    check("midrun_rst_running", 32'(running), 32'd0);
    check("midrun_rst_tick", 32'(tick), 32'd0);
    check("midrun_rst_wrap", 32'(wrap), 32'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk_video);
    check("post_rst_running", 32'(running), 32'd0);
    check("post_rst_count", 32'(count), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
